// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState_e;

  // Word index of a byte address: drop the byte offset and keep addrW bits,
  // so higher address bits wrap modulo the memory depth.
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int addrW);
    logic [31:0] mask_s;
    mask_s = (32'd1 << addrW) - 32'd1;
    return (addr >> 2) & mask_s;
  endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Word-organised storage: synchronous write, registered synchronous read,
// whole-array clear on reset. The read register doubles as the load result.
module word_ram
  import mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic              rdZero,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wrData,
  output logic [WORD_W-1:0] rdData
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Array clear on reset, otherwise commit the requested word write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WORD_W{1'b0}};
      end
    end else if (wrEn) begin
      mem_r[idx] <= wrData;
    end
  end

  // Read register: loads a word (or zero for a rejected read) and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdData <= {WORD_W{1'b0}};
    end else if (rdEn) begin
      rdData <= rdZero ? {WORD_W{1'b0}} : mem_r[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder with a fixed access latency. Holds the
// pipeline through stall until each access completes, then releases it for
// exactly one DONE cycle in which the load result and error pulse appear.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        read_valid,
  output logic        access_err
);

  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         HAS_LAT  = (LATENCY != 0);

  memState_e         state_r, nextState_s;
  logic [3:0]        cnt_r, nextCnt_s;
  logic              complete_s, selLatch_s;

  logic [ADDR_W-1:0] latchIdx_r;
  logic [31:0]       latchData_r;
  logic              latchRd_r, latchWr_r, latchMis_r;

  logic              req_s;
  logic [ADDR_W-1:0] inIdx_s, accIdx_s;
  logic [31:0]       accData_s;
  logic              accRd_s, accWr_s, accMis_s, accRdOnly_s, accConf_s;
  logic              ramWrEn_s, ramRdEn_s;

  assign req_s   = mem_read | mem_write;
  assign inIdx_s = ADDR_W'(word_idx(address, ADDR_W));

  // Combinational stall so the pipeline freezes in the cycle the request appears.
  assign stall = ((state_r == IDLE) && req_s && HAS_LAT) || (state_r == BUSY);

  // Next-state and completion decode; completion marks the edge entering DONE
  // (or the request edge itself when there is no latency).
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    complete_s  = 1'b0;
    selLatch_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (LATENCY == 0) begin
            complete_s  = 1'b1;
            nextState_s = IDLE;
          end else if (LATENCY == 1) begin
            complete_s  = 1'b1;
            nextState_s = DONE;
          end else begin
            nextState_s = BUSY;
            nextCnt_s   = CNT_INIT;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          nextState_s = DONE;
          complete_s  = 1'b1;
          selLatch_s  = 1'b1;
        end else begin
          nextCnt_s   = cnt_r - 4'd1;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Access fields: the latched copy while BUSY, the live request otherwise.
  always_comb begin
    if (selLatch_s) begin
      accIdx_s  = latchIdx_r;
      accData_s = latchData_r;
      accRd_s   = latchRd_r;
      accWr_s   = latchWr_r;
      accMis_s  = latchMis_r;
    end else begin
      accIdx_s  = inIdx_s;
      accData_s = write_data;
      accRd_s   = mem_read;
      accWr_s   = mem_write;
      accMis_s  = (address[1:0] != 2'b00);
    end
  end

  // A simultaneous read+write is served as a write and flagged as an error.
  assign accRdOnly_s = accRd_s & ~accWr_s;
  assign accConf_s   = accRd_s & accWr_s;
  assign ramWrEn_s   = complete_s & accWr_s & ~accMis_s;
  assign ramRdEn_s   = complete_s & accRdOnly_s;

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
    end
  end

  // Request latch, captured when a request is accepted from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      latchIdx_r  <= {ADDR_W{1'b0}};
      latchData_r <= 32'd0;
      latchRd_r   <= 1'b0;
      latchWr_r   <= 1'b0;
      latchMis_r  <= 1'b0;
    end else if ((state_r == IDLE) && req_s) begin
      latchIdx_r  <= inIdx_s;
      latchData_r <= write_data;
      latchRd_r   <= mem_read;
      latchWr_r   <= mem_write;
      latchMis_r  <= (address[1:0] != 2'b00);
    end
  end

  // One-cycle completion pulses for load results and rejected accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_valid <= 1'b0;
      access_err <= 1'b0;
    end else begin
      read_valid <= ramRdEn_s;
      access_err <= complete_s & (accMis_s | accConf_s);
    end
  end

  word_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .wrEn  (ramWrEn_s),
    .rdEn  (ramRdEn_s),
    .rdZero(accMis_s),
    .idx   (accIdx_s),
    .wrData(accData_s),
    .rdData(read_data)
  );

endmodule
